// File: rtl/mux2.sv
// mux2: parameterised 2:1 word multiplexer for the datapath.
// Combinational result plus an optional enabled register tap.
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  // Ternary keeps X-propagation on an unknown select in simulation
  assign y = s ? d1 : d0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else if (en) begin
      y_q <= y;
    end
  end

endmodule

// File: tb/tb_mux2.sv
// tb_mux2: randomized self-checking bench for mux2.
// Two instances: WIDTH=9 and the default WIDTH=32.
module tb_mux2;

  logic       clk;
  logic       rst9_n;
  logic [8:0] d0_9, d1_9, y9, yq9;
  logic       s9, en9;

  logic        rst32_n;
  logic [31:0] d0_32, d1_32, y32, yq32;
  logic        s32, en32;

  logic [8:0]  m9;
  logic [31:0] m32;
  int          n_run;
  int          n_fail;

  mux2 #(.WIDTH(9)) u_dut9 (
    .clk   (clk),
    .rst_n (rst9_n),
    .d0    (d0_9),
    .d1    (d1_9),
    .s     (s9),
    .en    (en9),
    .y     (y9),
    .y_q   (yq9)
  );

  mux2 u_dut32 (
    .clk   (clk),
    .rst_n (rst32_n),
    .d0    (d0_32),
    .d1    (d1_32),
    .s     (s32),
    .en    (en32),
    .y     (y32),
    .y_q   (yq32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] pick9(logic [8:0] a, logic [8:0] b,
                                       logic sel);
    logic [8:0] r;
    if (sel) r = b;
    else r = a;
    return r;
  endfunction

  function automatic logic [31:0] pick32(logic [31:0] a, logic [31:0] b,
                                         logic sel);
    logic [31:0] r;
    if (sel) r = b;
    else r = a;
    return r;
  endfunction

  // Advance one rising edge, updating the register models from the
  // values the DUT sees at that edge; returns 1ns after the edge.
  task automatic step();
    logic [8:0]  n9;
    logic [31:0] n32;
    n9 = m9;
    n32 = m32;
    if (!rst9_n) n9 = '0;
    else if (en9) n9 = pick9(d0_9, d1_9, s9);
    if (!rst32_n) n32 = '0;
    else if (en32) n32 = pick32(d0_32, d1_32, s32);
    @(posedge clk);
    m9 = n9;
    m32 = n32;
    #1;
  endtask

  task automatic chk9(string name, logic [8:0] act, logic [8:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst9_n = 0; rst32_n = 0;
    en9 = 1; s9 = 0; d0_9 = 9'h1FF; d1_9 = 9'h000;
    en32 = 1; s32 = 0; d0_32 = '0; d1_32 = '0;
    m9 = '0; m32 = '0;
    #2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk9("reset_yq", yq9, 9'h000);
      chk9("reset_y", y9, 9'h1FF);
    end
    n_run++;
    if (yq32 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_yq32: got %h expected 0", yq32);
    end
  endtask

  task automatic test_comb();
    d0_9 = 9'h155; d1_9 = 9'h199; s9 = 0;
    #1 chk9("comb_s0", y9, 9'h155);
    s9 = 1;
    #1 chk9("comb_s1", y9, 9'h199);
    s9 = 0;
    #1 chk9("comb_s0b", y9, 9'h155);
  endtask

  task automatic test_load();
    rst9_n = 1;
    en9 = 1; s9 = 1; d1_9 = 9'h0AA;
    step();
    chk9("load_first", yq9, 9'h0AA);
    s9 = 0; d0_9 = 9'h123;
    step();
    chk9("load_second", yq9, 9'h123);
  endtask

  task automatic test_hold();
    en9 = 0;
    for (int i = 0; i < 3; i++) begin
      d0_9 = 9'($urandom); d1_9 = 9'($urandom); s9 = 1'($urandom);
      #1 chk9("hold_y", y9, pick9(d0_9, d1_9, s9));
      step();
      chk9("hold_yq", yq9, 9'h123);
    end
  endtask

  task automatic test_async_reset();
    en9 = 1; s9 = 1; d1_9 = 9'h0F0;
    #3;
    rst9_n = 0;
    m9 = '0;
    #1;
    chk9("async_yq", yq9, 9'h000);
    chk9("async_y", y9, 9'h0F0);
    step();
    chk9("async_hold", yq9, 9'h000);
    #2 rst9_n = 1;
    step();
    chk9("async_release", yq9, 9'h0F0);
  endtask

  task automatic test_equal();
    for (int i = 0; i < 6; i++) begin
      d0_9 = 9'($urandom);
      d1_9 = d0_9;
      s9 = 1'($urandom);
      #1 chk9("equal_y", y9, d0_9);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      d0_9 = 9'($urandom); d1_9 = 9'($urandom);
      s9 = 1'($urandom); en9 = 1'($urandom);
      #1 chk9("rand_y", y9, pick9(d0_9, d1_9, s9));
      step();
      chk9("rand_yq", yq9, m9);
    end
  endtask

  task automatic test_width32();
    logic [31:0] prev;
    rst32_n = 1;
    en32 = 1; d0_32 = 32'hDEADBEEF; d1_32 = 32'h00000004; s32 = 0;
    prev = 32'h0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_run++;
      if (y32 !== pick32(d0_32, d1_32, s32)) begin
        n_fail++;
        $display("FAIL w32_y: got %h expected %h", y32,
                 pick32(d0_32, d1_32, s32));
      end
      prev = pick32(d0_32, d1_32, s32);
      step();
      n_run++;
      if (yq32 !== prev || yq32 !== m32) begin
        n_fail++;
        $display("FAIL w32_yq: got %h expected %h", yq32, prev);
      end
      s32 = ~s32;
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_comb();
    test_load();
    test_hold();
    test_async_reset();
    test_equal();
    test_random();
    test_width32();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2.md
Name: mux2

Overview:
- Parameterised 2:1 word multiplexer used in the single-cycle RISC-V datapath (PC-next select, ALU operand B select, writeback select).
- Provides a purely combinational output `y` for same-cycle datapath use.
- Also provides an optional registered copy `y_q` for timing-closure or debug taps; it shares one clock and an asynchronous active-low reset.

Parameters:
- WIDTH, default 32: bit width of d0, d1, y, y_q; legal range 1..64.

Ports:
- clk  input  1  single clock; rising edge; used only by the registered path.
- rst_n  input  1  asynchronous, active-low reset; clears the registered path.
- d0  input  WIDTH  data input selected when s=0.
- d1  input  WIDTH  data input selected when s=1.
- s  input  1  select.
- en  input  1  load enable for y_q; when low, y_q holds.
- y  output  WIDTH  combinational mux result.
- y_q  output  WIDTH  registered mux result.

Behaviour:
- y = s ? d1 : d0, purely combinational.
  - Zero-cycle latency; y updates in the same delta on any change of d0, d1 or s.
  - y is independent of clk, rst_n and en, and is valid during reset.
- s unknown (X/Z): y is X in simulation. No priority is given to either input.
- y_q register:
  - rst_n low: y_q cleared to all zeros immediately, without waiting for a clock edge. It stays zero while rst_n is low.
  - Rising clk with rst_n high and en=1: y_q <= (s ? d1 : d0), sampled at the edge. Latency is 1 cycle.
  - Rising clk with en=0: y_q holds its previous value.
  - Reset deassertion is synchronised by the system reset controller. The first load occurs on the first rising edge after rst_n is high.
  - Reset asserted mid-operation: y_q clears immediately and the pending sample is discarded. y is unaffected.
- Width rules: no extension and no truncation; all data ports are exactly WIDTH bits. Inputs are unsigned bit vectors.
- d0 == d1: y equals that value regardless of s.
- No internal state beyond the y_q register; no handshakes.

Test Plan:
- WIDTH=9, d0=9'h155, d1=9'h199, s=0 → y=9'h155. At t=10ns set s=1 → y=9'h199 with no clock edge required. At t=20ns set s=0 → y=9'h155.
- WIDTH=9, rst_n=0 with clk toggling, d0=9'h1FF → y_q=0 throughout and y=9'h1FF.
- Release rst_n, en=1, s=1, d1=9'h0AA → y_q=9'h0AA after the first rising edge. Then s=0, d0=9'h123 → y_q=9'h123 one edge later.
- en=0 with d0, d1 and s changing over 3 cycles → y_q holds its last loaded value while y tracks the inputs.
- With y_q=9'h123, drop rst_n mid-cycle (between edges) → y_q=0 immediately. y still equals the selected input.
- WIDTH=32 default: d0=32'hDEADBEEF, d1=32'h00000004, s toggling each cycle with en=1 → y and y_q match the selection, with y_q lagging by one cycle.
